pos_arb_fl: RTL and testbench

- Shares one floating-point unary post-processing datapath (pass, NEG, ABS, PSET) between NREQ requesters, e.g. several processor cores or DMA channels in a multi-core build.
- Arbitrates round-robin and accepts one request per cycle.
- Applies the selected sign/clamp operation and returns the result, tagged with the requester index, through a registered valid/ready output.

---
 rtl/pos_arb_fl.sv | 147 ++++++++++++++
 tb/tb_pos_arb_fl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pos_arb_fl.sv
// rtl/pos_arb_fl.sv - round-robin shared fp sign/clamp unit (optional POS_ARB_FL_CNT_EN counters)
module pos_arb_fl #(
  parameter int NBMANT = 22,
  parameter int NBEXPO = 6,
  parameter int NREQ   = 4,
  parameter int PSTS   = 1,
  parameter int ABSS   = 1,
  parameter int NEGS   = 1,
  localparam int W     = NBMANT + NBEXPO + 1,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [2*NREQ-1:0]   req_op,
  input  logic [W*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [IDW-1:0]      res_id,
  output logic [W-1:0]        res_data,
  output logic                res_err
`ifdef POS_ARB_FL_CNT_EN
  ,
  output logic [31:0]         op_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] gnt_idx;
  logic           found;
  logic           can_accept;
  logic           accept;
  logic [1:0]     sel_op;
  logic [W-1:0]   sel_data;
  logic [W-1:0]   op_data;
  logic           op_err;

  assign res_valid  = (state == FULL);
  assign can_accept = (state == EMPTY) || res_ready;

  // Search for the first valid requester starting at rr_ptr, wrapping at NREQ.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // One-hot grant, suppressed under reset, when the output is blocked or nothing pends.
  always_comb begin
    req_ready = '0;
    if (rst && can_accept && found)
      req_ready = NREQ'(1) << gnt_idx;
  end

  assign accept = |(req_valid & req_ready);

  // Route the granted requester's op and operand to the shared datapath.
  always_comb begin
    sel_op   = 2'b00;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_op   = req_op[2*i +: 2];
        sel_data = req_data[W*i +: W];
      end
    end
  end

  // Sign/clamp operations; an op built without support passes the operand and flags it.
  always_comb begin
    op_data = sel_data;
    op_err  = 1'b0;
    case (sel_op)
      2'b01: begin
        if (NEGS != 0) op_data = {~sel_data[W-1], sel_data[W-2:0]};
        else           op_err  = 1'b1;
      end
      2'b10: begin
        if (ABSS != 0) op_data = {1'b0, sel_data[W-2:0]};
        else           op_err  = 1'b1;
      end
      2'b11: begin
        if (PSTS != 0) begin
          if (sel_data[W-1]) op_data = {2'b01, {(W-2){1'b0}}};
        end else begin
          op_err = 1'b1;
        end
      end
      default: op_data = sel_data;
    endcase
  end

  // Output register FSM plus round-robin pointer advance on each accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      res_id   <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) state <= FULL;
        end
        FULL: begin
          if (!accept && res_ready) state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
      if (accept) begin
        res_id   <= gnt_idx;
        res_data <= op_data;
        res_err  <= op_err;
        rr_ptr   <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

`ifdef POS_ARB_FL_CNT_EN
  // Saturating counts of accepted requests and of stalled output cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && op_cnt != 32'hFFFF_FFFF) op_cnt <= op_cnt + 32'd1;
      if (res_valid && !res_ready && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pos_arb_fl.sv
// tb/tb_pos_arb_fl.sv - directed self-checking bench for pos_arb_fl
module tb_pos_arb_fl;

  localparam int W    = 29;
  localparam int NREQ = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req_valid;
  logic [7:0]      req_op;
  logic [W*4-1:0]  req_data;
  logic            res_ready;

  logic [3:0]      req_ready,  na_req_ready;
  logic            res_valid,  na_res_valid;
  logic [1:0]      res_id,     na_res_id;
  logic [W-1:0]    res_data,   na_res_data;
  logic            res_err,    na_res_err;
`ifdef POS_ARB_FL_CNT_EN
  logic [31:0]     op_cnt, stall_cnt, na_op_cnt, na_stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pos_arb_fl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_data(res_data), .res_err(res_err)
`ifdef POS_ARB_FL_CNT_EN
    , .op_cnt(op_cnt), .stall_cnt(stall_cnt)
`endif
  );

  pos_arb_fl #(.ABSS(0)) dut_na (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_ready(na_req_ready),
    .res_valid(na_res_valid), .res_ready(res_ready),
    .res_id(na_res_id), .res_data(na_res_data), .res_err(na_res_err)
`ifdef POS_ARB_FL_CNT_EN
    , .op_cnt(na_op_cnt), .stall_cnt(na_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] d);
    req_op[2*i +: 2]  = op;
    req_data[W*i +: W] = d;
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 4'hF;
    req_op    = '0;
    req_data  = '0;
    res_ready = 1'b1;
    step();
    step();
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_id",    64'(res_id),    64'd0);
    check("rst_data",  64'(res_data),  64'd0);
    check("rst_err",   64'(res_err),   64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    req_valid = 4'h0;
    rst = 1'b1;
    #1;

    // single NEG on requester 0
    set_req(0, 2'b01, 29'h0400_0000);
    req_valid = 4'b0001;
    #1;
    check("neg_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = 4'b0000;
    check("neg_valid", 64'(res_valid), 64'd1);
    check("neg_id",    64'(res_id),    64'd0);
    check("neg_data",  64'(res_data),  64'h1400_0000);
    check("neg_err",   64'(res_err),   64'd0);

    // ABS on requester 1
    set_req(1, 2'b10, 29'h1400_0000);
    req_valid = 4'b0010;
    #1;
    check("abs_ready", 64'(req_ready), 64'h2);
    step();
    req_valid = 4'b0000;
    check("abs_id",   64'(res_id),   64'd1);
    check("abs_data", 64'(res_data), 64'h0400_0000);

    // PSET with sign set on requester 2
    set_req(2, 2'b11, 29'h1400_0000);
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    check("pset_neg_id",   64'(res_id),   64'd2);
    check("pset_neg_data", 64'(res_data), 64'h0800_0000);

    // PSET with sign clear on requester 3
    set_req(3, 2'b11, 29'h0123_4567);
    req_valid = 4'b1000;
    step();
    req_valid = 4'b0000;
    check("pset_pos_id",   64'(res_id),   64'd3);
    check("pset_pos_data", 64'(res_data), 64'h0123_4567);

    // ABS on requester 0: supported in dut, disabled in dut_na
    set_req(0, 2'b10, 29'h1000_0001);
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    check("abs_on_data",  64'(res_data),    64'h0000_0001);
    check("abs_on_err",   64'(res_err),     64'd0);
    check("abs_off_data", 64'(na_res_data), 64'h1000_0001);
    check("abs_off_err",  64'(na_res_err),  64'd1);

    // pass on requester 3 brings the pointer back to 0
    set_req(3, 2'b00, 29'h1ABC_DEF0);
    req_valid = 4'b1000;
    step();
    req_valid = 4'b0000;
    check("pass_data", 64'(res_data), 64'h1ABC_DEF0);

    // round robin with all four continuously valid
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b00, W'(32'h100 + i));
    req_valid = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      #1;
      check($sformatf("rr_ready%0d", n), 64'(req_ready), 64'(4'b0001 << (n % 4)));
      step();
      check($sformatf("rr_valid%0d", n), 64'(res_valid), 64'd1);
      check($sformatf("rr_id%0d", n),    64'(res_id),    64'(n % 4));
      check($sformatf("rr_data%0d", n),  64'(res_data),  64'(32'h100 + (n % 4)));
    end
    req_valid = 4'b0000;
    step();
    check("drain_valid", 64'(res_valid), 64'd0);

    // backpressure: pointer is 2, requesters 1 and 2 pending
    set_req(1, 2'b00, 29'h0AAA_AAAA);
    set_req(2, 2'b01, 29'h0000_0005);
    res_ready = 1'b0;
    req_valid = 4'b0110;
    #1;
    check("bp_first_ready", 64'(req_ready), 64'h4);
    step();
    for (int n = 0; n < 5; n++) begin
      check($sformatf("bp_ready%0d", n), 64'(req_ready), 64'd0);
      check($sformatf("bp_id%0d", n),    64'(res_id),    64'd2);
      check($sformatf("bp_data%0d", n),  64'(res_data),  64'h1000_0005);
      check($sformatf("bp_valid%0d", n), 64'(res_valid), 64'd1);
      step();
    end
`ifdef POS_ARB_FL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'd5);
`endif
    res_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(req_ready), 64'h2);
    step();
    req_valid = 4'b0000;
    check("bp_next_id",   64'(res_id),   64'd1);
    check("bp_next_data", 64'(res_data), 64'h0AAA_AAAA);
    step();
    check("bp_no_dup", 64'(res_valid), 64'd0);

    // async reset while a result is held
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    res_ready = 1'b0;
    check("pre_rst_valid", 64'(res_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_valid", 64'(res_valid), 64'd0);
    check("async_data",  64'(res_data),  64'd0);
`ifdef POS_ARB_FL_CNT_EN
    check("async_op_cnt",    64'(op_cnt),    64'd0);
    check("async_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    step();
    rst = 1'b1;
    res_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = 4'b0000;
    check("post_rst_id", 64'(res_id), 64'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
